// File: rtl/karatsuba_split_mul_24bit_pkg.sv
// Shared constants and FSM state type for the Karatsuba carry-less multiplier levels.
package karatsuba_pkg;

  localparam int unsigned N      = 24;
  localparam int unsigned HALF   = N / 2;
  localparam int unsigned PROD_W = N - 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_LO  = 3'd1,
    MUL_HI  = 3'd2,
    MUL_MID = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/karatsuba_split_mul_24bit_if.sv
// Operand/result handshake bundle for the split Karatsuba multiplier.
interface karatsuba_split_mul_24bit_if #(
  parameter int unsigned N = karatsuba_pkg::N
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-2:0] t_lo;
  logic [N-2:0] t_mid;
  logic [N-2:0] t_hi;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, t_lo, t_mid, t_hi
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, t_lo, t_mid, t_hi
  );

endinterface

// File: rtl/karatsuba_split_mul_24bit_clmul.sv
// Serial HALF x HALF carry-less multiplier: one multiplier bit per enabled cycle, LSB first.
module clmul_serial_half #(
  parameter int unsigned HALF = karatsuba_pkg::HALF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [HALF-1:0]   mcand,
  input  logic [HALF-1:0]   mplier,
  output logic [2*HALF-2:0] prod,
  output logic              last
);

  localparam int unsigned PW = 2 * HALF - 1;
  localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt;
  logic [PW-1:0] acc;
  logic [PW-1:0] partial;

  // prod is the running sum including this cycle's term, so it is the
  // finished product during the cycle that last is high.
  always_comb begin
    partial = '0;
    if (mplier[cnt]) partial = PW'(mcand) << cnt;
    prod = ((cnt == '0) ? '0 : acc) ^ partial;
  end

  assign last = en && (cnt == CW'(HALF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (en) begin
      acc <= prod;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/karatsuba_split_mul_24bit.sv
// One Karatsuba level: three time-shared half-width carry-less products (lo, hi, mid).
module karatsuba_split_mul_24bit #(
  parameter int unsigned N = karatsuba_pkg::N
) (
  input  logic                        clk,
  input  logic                        rst_n,
  karatsuba_split_mul_24bit_if.slave  bus,
  output logic                        busy
);

  import karatsuba_pkg::*;

  localparam int unsigned H  = N / 2;
  localparam int unsigned PW = N - 1;

  state_t        state, state_nxt;
  logic [N-1:0]  a_q, b_q;
  logic [H-1:0]  mcand, mplier;
  logic [PW-1:0] prod;
  logic [PW-1:0] t_lo_q, t_mid_q, t_hi_q;
  logic          mul_en, last;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign busy          = (state != IDLE);
  assign bus.t_lo      = t_lo_q;
  assign bus.t_mid     = t_mid_q;
  assign bus.t_hi      = t_hi_q;
  assign mul_en        = (state == MUL_LO) || (state == MUL_HI) || (state == MUL_MID);

  always_comb begin
    mcand  = '0;
    mplier = '0;
    case (state)
      MUL_LO:  begin mcand = a_q[H-1:0]; mplier = b_q[H-1:0]; end
      MUL_HI:  begin mcand = a_q[N-1:H]; mplier = b_q[N-1:H]; end
      MUL_MID: begin
        mcand  = a_q[H-1:0] ^ a_q[N-1:H];
        mplier = b_q[H-1:0] ^ b_q[N-1:H];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = MUL_LO;
      MUL_LO:  if (last)          state_nxt = MUL_HI;
      MUL_HI:  if (last)          state_nxt = MUL_MID;
      MUL_MID: if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  clmul_serial_half #(.HALF(H)) u_clmul (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (mul_en),
    .mcand  (mcand),
    .mplier (mplier),
    .prod   (prod),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      t_lo_q  <= '0;
      t_mid_q <= '0;
      t_hi_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.in_valid) begin
        a_q <= bus.a;
        b_q <= bus.b;
      end
      // t_lo/t_hi double as the P0/P2 holding registers for the mid fold-in.
      if (last) begin
        case (state)
          MUL_LO:  t_lo_q  <= prod;
          MUL_HI:  t_hi_q  <= prod;
          MUL_MID: t_mid_q <= prod ^ t_lo_q ^ t_hi_q;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/karatsuba_split_mul_24bit.md
KARATSUBA_SPLIT_MUL_24BIT -- requirements
Module: karatsuba_split_mul_24bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock port clk, reset port rst_n.
REQ-002 Parameter N, default 24, is the operand width; N SHALL be even.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand pair presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  N  operand A, GF(2) polynomial, bit i = coefficient of x^i.
REQ-008 b  input  N  operand B, same encoding.
REQ-009 out_valid  output  1  partial-product triple valid.
REQ-010 out_ready  input  1  consumer accepts the triple.
REQ-011 t_lo  output  N-1  aL*bL, carry-less.
REQ-012 t_mid  output  N-1  (aL^aH)*(bL^bH) ^ t_lo ^ t_hi.
REQ-013 t_hi  output  N-1  aH*bH, carry-less.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Operands SHALL split as aL=a[N/2-1:0], aH=a[N-1:N/2]; b likewise.
REQ-016 All arithmetic SHALL be GF(2): addition is XOR, multiplication carry-less, with no carries anywhere.
REQ-017 FSM states SHALL be IDLE, MUL_LO, MUL_HI, MUL_MID, DONE.
REQ-018 in_ready SHALL equal (state==IDLE); in_valid in any other state SHALL be ignored.
REQ-019 Accept on in_valid&&in_ready (cycle C): a and b are registered, and the next state is MUL_LO.
REQ-020 Each MUL_* state SHALL last exactly N/2 cycles (12 at default), one multiplier bit per cycle, LSB first, using shift-and-XOR.
REQ-021 The sequence SHALL be MUL_LO -> MUL_HI -> MUL_MID -> DONE with no idle cycles between states.
REQ-022 On the final MUL_MID cycle, t_mid SHALL be registered as Pm^P0^P2.
REQ-023 out_valid SHALL rise at cycle C+3*(N/2)+1 (C+37 at default).
REQ-024 In DONE, out_valid SHALL be 1; t_lo, t_mid and t_hi SHALL remain stable while out_ready=0, with unlimited back-pressure.
REQ-025 On out_valid&&out_ready, the next state SHALL be IDLE and out_valid SHALL deassert the next cycle.
REQ-026 Outputs SHALL be in the exact lower/middle/upper form that the 24-bit overlap combiner consumes: t_mid aligns at bit N/2, t_hi at bit N.
REQ-027 Minimum throughput is one product per 3*(N/2)+2 cycles; back-to-back accepts SHALL NOT occur.
REQ-028 A zero operand SHALL take the same latency as any other operand, with no early exit.

Reset
REQ-029 Asserting rst_n low SHALL immediately force state=IDLE, out_valid=0, busy=0, and t_lo=t_mid=t_hi=0, with in_ready=1 while in reset.
REQ-030 Reset mid-operation SHALL discard the in-flight operands; no partial result SHALL ever appear with out_valid=1.
REQ-031 The first accept SHALL be possible on the first clock edge after rst_n deasserts.

Structure
REQ-032 A shared package karatsuba_pkg SHALL hold N, HALF=N/2, PROD_W=N-1 and the FSM state enum, for reuse by the other Karatsuba levels.
REQ-033 One sub-module, clmul_serial_half, SHALL provide the iterative HALF x HALF carry-less multiplier; it is instantiated once and time-shared across the three products.
REQ-034 The parent SHALL contain only the FSM, operand and accumulator registers, and the handshake logic.

Verification
REQ-035 a=0x000001, b=0x000001 -> after 37 cycles, t_lo=0x000001, t_mid=0, t_hi=0.
REQ-036 a=0xFFFFFF, b=0xFFFFFF -> t_lo=0x555555, t_hi=0x555555, t_mid=0.
REQ-037 a=0x001000, b=0x000001 -> t_lo=0, t_hi=0, t_mid=0x000001 (product x^12).
REQ-038 out_ready held 0 for 10 cycles in DONE -> out_valid and outputs stable throughout; in_valid pulses are ignored and in_ready stays 0.
REQ-039 rst_n pulsed low during MUL_HI -> outputs zero and state IDLE; a new accept yields the correct result with no corruption.
REQ-040 10k random a,b -> the overlap of (t_lo, t_mid, t_hi) equals a software carry-less 24x24 product, with a latency of 37 on every case.
